// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-add per clock, LSB first, fixed WIDTH+1 cycle latency.
// Defining SERIAL_ADDER_OVF_EN adds the registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_sh_reg;
  logic [WIDTH-1:0]   b_sh_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               carry_reg;
  logic               cout_reg;
  logic               bit_sum;
  logic               bit_carry;
  logic               last_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_reg;
`endif

  assign bit_sum   = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
  assign bit_carry = (a_sh_reg[0] & b_sh_reg[0]) | (carry_reg & (a_sh_reg[0] ^ b_sh_reg[0]));
  assign last_bit  = (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers only change while running, so they hold through IDLE until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else if (state_reg == IDLE && start) begin
      a_sh_reg  <= a;
      b_sh_reg  <= b;
      carry_reg <= cin;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg  <= a_sh_reg >> 1;
      b_sh_reg  <= b_sh_reg >> 1;
      sum_reg   <= {bit_sum, sum_reg[WIDTH-1:1]};
      carry_reg <= bit_carry;
      cnt_reg   <= cnt_reg + CNT_W'(1);
      if (last_bit) begin
        cout_reg <= bit_carry;
`ifdef SERIAL_ADDER_OVF_EN
        // carry_reg here is the carry into the MSB.
        ovf_reg  <= carry_reg ^ bit_carry;
`endif
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8), directed cases plus randomized traffic.
// Expected results come from plain integer arithmetic; a forked monitor checks every done pulse.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: unsigned sum with carry and signed-range overflow, straight from arithmetic.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input bit push, output int k);
    exp_t e;
    int   s;
    logic [W:0] full;
    start = 1'b1;
    a     = ia;
    b     = ib;
    cin   = ic;
    @(posedge clk);
    #1;
    k     = cyc;
    start = 1'b0;
    if (push) begin
      full   = {1'b0, ia} + {1'b0, ib} + (W+1)'(ic);
      e.sum  = full[W-1:0];
      e.cout = full[W];
      s      = int'($signed(ia)) + int'($signed(ib)) + int'(ic);
      e.ovf  = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
      e.cyc  = k + W;
      sb_q.push_back(e);
    end
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          $display("txn cycle %0d: sum=%02h cout=%0d expected sum=%02h cout=%0d",
                   cyc, sum, cout, e.sum, e.cout);
          check("sum", 32'(sum), 32'(e.sum));
          check("cout", 32'(cout), 32'(e.cout));
          check("done_latency", 32'(cyc), 32'(e.cyc));
          check("busy_in_done", 32'(busy), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
          check("ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
      end
    end
  endtask

  initial begin
    int k;
    int last_k;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    fork
      run_monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 35+4A: busy for exactly 9 cycles, then idle.
    issue(8'h35, 8'h4A, 1'b0, 1'b1, k);
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      check("busy_run", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Starts during RUN and DONE are ignored; operand changes do not disturb the result.
    issue(8'h10, 8'h20, 1'b0, 1'b1, k);
    goto_cyc(k + 2);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    goto_cyc(k + 3);
    start = 1'b0;
    goto_cyc(k + 8);
    start = 1'b1;
    goto_cyc(k + 9);
    start = 1'b0;
    @(negedge clk);
    check("no_requeue_busy", 32'(busy), 32'd0);
    goto_cyc(k + 12);
    @(negedge clk);
    check("no_requeue_busy2", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Carry-in only, then all-ones wrap; second start on first IDLE cycle.
    issue(8'h00, 8'h00, 1'b1, 1'b1, k);
    goto_cyc(k + W + 1);
    issue(8'hFF, 8'h01, 1'b0, 1'b1, k);
    goto_cyc(k + W + 1);

    // Reset mid-operation: outputs clear at once and no done follows.
    issue(8'hAA, 8'h55, 1'b0, 1'b0, k);
    goto_cyc(k + 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_sum", 32'(sum), 32'd0);
    check("async_rst_cout", 32'(cout), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(8'hAA, 8'h55, 1'b1, 1'b1, k);
    goto_cyc(k + W + 1);

    // Signed overflow boundaries.
    issue(8'h7F, 8'h01, 1'b0, 1'b1, k);
    goto_cyc(k + W + 1);
    issue(8'h80, 8'hFF, 1'b0, 1'b1, k);
    goto_cyc(k + W + 1);
    issue(8'h05, 8'hFE, 1'b0, 1'b1, k);
    goto_cyc(k + W + 1);

    // Random back-to-back traffic with junk inputs and stray starts while busy.
    for (int t = 0; t < 40; t++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1, k);
      for (int i = 1; i <= W + 1; i++) begin
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        start = 1'($urandom);
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    last_k = cyc;
    goto_cyc(last_k + W + 3);
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
